// File: rtl/eth_tx_arbiter.sv
// Three-source (ARP/PING/UDP) packet arbiter onto one 32-bit TX stream.
// Fixed priority with UDP anti-starvation, stall timeout with forced eop and drain.
module eth_tx_arbiter #(
  parameter int unsigned TIMEOUT    = 1024,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic [31:0] i_arp_data,
  input  logic        i_arp_vld,
  input  logic        i_arp_sop,
  input  logic        i_arp_eop,
  output logic        o_arp_rdy,

  input  logic [31:0] i_ping_data,
  input  logic        i_ping_vld,
  input  logic        i_ping_sop,
  input  logic        i_ping_eop,
  output logic        o_ping_rdy,

  input  logic [31:0] i_udp_data,
  input  logic        i_udp_vld,
  input  logic        i_udp_sop,
  input  logic        i_udp_eop,
  output logic        o_udp_rdy,

  output logic [31:0] o_tx_data,
  output logic        o_tx_vld,
  output logic        o_tx_sop,
  output logic        o_tx_eop,
  input  logic        i_tx_rdy,

  output logic [1:0]  o_grant,
  output logic        o_busy,
  output logic        o_timeout,
  output logic [7:0]  o_drop_cnt
);

  localparam int unsigned DW = 32;
  localparam int unsigned SW = 3;
  localparam int unsigned IW = $clog2(TIMEOUT + 1);
  localparam int unsigned CW = 8;

  localparam logic [1:0]    G_NONE = 2'd0;
  localparam logic [1:0]    G_ARP  = 2'd1;
  localparam logic [1:0]    G_PING = 2'd2;
  localparam logic [1:0]    G_UDP  = 2'd3;
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
  localparam logic [IW-1:0] IDLE_LAST  = IW'(TIMEOUT - 1);
  localparam logic [CW-1:0] DROP_SAT   = '1;

  typedef enum logic [1:0] {IDLE, GRANT, ABORT, DRAIN} state_t;

  state_t        state_q, state_d;
  logic [1:0]    grant_q, grant_d;
  logic [SW-1:0] starve_cnt_q, starve_cnt_d;
  logic [IW-1:0] idle_cnt_q, idle_cnt_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;
  logic          timeout_q, timeout_d;

  logic          req_arp, req_ping, req_udp;
  logic          stray_arp, stray_ping, stray_udp;
  logic [DW-1:0] own_data;
  logic          own_vld, own_sop, own_eop, own_rdy;
  logic [DW-1:0] tx_data;
  logic          tx_vld, tx_sop, tx_eop;
  logic          arp_rdy, ping_rdy, udp_rdy;

  assign req_arp    = i_arp_vld  & i_arp_sop;
  assign req_ping   = i_ping_vld & i_ping_sop;
  assign req_udp    = i_udp_vld  & i_udp_sop;
  assign stray_arp  = i_arp_vld  & ~i_arp_sop;
  assign stray_ping = i_ping_vld & ~i_ping_sop;
  assign stray_udp  = i_udp_vld  & ~i_udp_sop;

  // Current owner's stream, selected by the registered grant
  always_comb begin
    own_data = '0;
    own_vld  = 1'b0;
    own_sop  = 1'b0;
    own_eop  = 1'b0;
    case (grant_q)
      G_ARP: begin
        own_data = i_arp_data;
        own_vld  = i_arp_vld;
        own_sop  = i_arp_sop;
        own_eop  = i_arp_eop;
      end
      G_PING: begin
        own_data = i_ping_data;
        own_vld  = i_ping_vld;
        own_sop  = i_ping_sop;
        own_eop  = i_ping_eop;
      end
      G_UDP: begin
        own_data = i_udp_data;
        own_vld  = i_udp_vld;
        own_sop  = i_udp_sop;
        own_eop  = i_udp_eop;
      end
      G_NONE: ;
    endcase
  end

  // Next-state, counters and stream outputs
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    starve_cnt_d = starve_cnt_q;
    idle_cnt_d   = idle_cnt_q;
    drop_cnt_d   = drop_cnt_q;
    timeout_d    = 1'b0;
    tx_data      = '0;
    tx_vld       = 1'b0;
    tx_sop       = 1'b0;
    tx_eop       = 1'b0;
    own_rdy      = 1'b0;
    arp_rdy      = 1'b0;
    ping_rdy     = 1'b0;
    udp_rdy      = 1'b0;

    case (state_q)
      IDLE: begin
        arp_rdy    = stray_arp;
        ping_rdy   = stray_ping;
        udp_rdy    = stray_udp;
        idle_cnt_d = '0;
        if ((stray_arp | stray_ping | stray_udp) && (drop_cnt_q != DROP_SAT)) begin
          drop_cnt_d = drop_cnt_q + CW'(1);
        end
        if (req_arp | req_ping | req_udp) begin
          state_d = GRANT;
          if (req_udp && (starve_cnt_q == STARVE_LIM)) grant_d = G_UDP;
          else if (req_arp)                           grant_d = G_ARP;
          else if (req_ping)                          grant_d = G_PING;
          else                                        grant_d = G_UDP;
          // UDP loses a round only when it was actually waiting
          if (grant_d == G_UDP) begin
            starve_cnt_d = '0;
          end else if (req_udp && (starve_cnt_q < STARVE_LIM)) begin
            starve_cnt_d = starve_cnt_q + SW'(1);
          end
        end
      end

      GRANT: begin
        tx_data = own_data;
        tx_vld  = own_vld;
        tx_sop  = own_sop;
        tx_eop  = own_eop;
        own_rdy = i_tx_rdy;
        if (own_vld && i_tx_rdy) begin
          idle_cnt_d = '0;
          if (own_eop) begin
            state_d = IDLE;
            grant_d = G_NONE;
          end
        end else if (!own_vld) begin
          if (idle_cnt_q == IDLE_LAST) begin
            state_d    = ABORT;
            timeout_d  = 1'b1;
            idle_cnt_d = '0;
          end else begin
            idle_cnt_d = idle_cnt_q + IW'(1);
          end
        end
      end

      ABORT: begin
        tx_vld = 1'b1;
        tx_eop = 1'b1;
        if (i_tx_rdy) begin
          state_d    = DRAIN;
          idle_cnt_d = '0;
        end
      end

      DRAIN: begin
        own_rdy = 1'b1;
        if (own_vld) begin
          idle_cnt_d = '0;
          if (own_eop) begin
            state_d = IDLE;
            grant_d = G_NONE;
          end
        end else if (idle_cnt_q == IDLE_LAST) begin
          state_d    = IDLE;
          grant_d    = G_NONE;
          idle_cnt_d = '0;
        end else begin
          idle_cnt_d = idle_cnt_q + IW'(1);
        end
      end
    endcase

    if (grant_q == G_ARP)  arp_rdy  = arp_rdy  | own_rdy;
    if (grant_q == G_PING) ping_rdy = ping_rdy | own_rdy;
    if (grant_q == G_UDP)  udp_rdy  = udp_rdy  | own_rdy;

    // Nothing moves on either side while reset is held
    if (!rst_n) begin
      tx_vld   = 1'b0;
      arp_rdy  = 1'b0;
      ping_rdy = 1'b0;
      udp_rdy  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      grant_q      <= G_NONE;
      starve_cnt_q <= '0;
      idle_cnt_q   <= '0;
      drop_cnt_q   <= '0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      starve_cnt_q <= starve_cnt_d;
      idle_cnt_q   <= idle_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
      timeout_q    <= timeout_d;
    end
  end

  assign o_tx_data  = tx_data;
  assign o_tx_vld   = tx_vld;
  assign o_tx_sop   = tx_sop;
  assign o_tx_eop   = tx_eop;
  assign o_arp_rdy  = arp_rdy;
  assign o_ping_rdy = ping_rdy;
  assign o_udp_rdy  = udp_rdy;
  assign o_grant    = grant_q;
  assign o_busy     = (state_q != IDLE);
  assign o_timeout  = timeout_q;
  assign o_drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Directed bench for eth_tx_arbiter: source queues feed the DUT, an expected-beat
// queue is filled at stimulus time and popped whenever a TX beat is accepted.
module tb_eth_tx_arbiter;

  localparam int unsigned TO = 16;
  localparam int unsigned SM = 4;

  typedef struct packed {
    logic [31:0] data;
    logic        sop;
    logic        eop;
    logic [1:0]  owner;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] s_data [3];
  logic        s_vld  [3];
  logic        s_sop  [3];
  logic        s_eop  [3];
  logic        s_rdy  [3];
  logic [31:0] tx_data;
  logic        tx_vld, tx_sop, tx_eop, tx_rdy;
  logic [1:0]  grant;
  logic        busy, timeout;
  logic [7:0]  drop_cnt;

  beat_t       src_q [3][$];
  beat_t       exp_q [$];
  logic        stall [3];
  logic [1:0]  grant_trace [$];
  logic [1:0]  exp_tr [13];
  int          vectors = 0;
  int          miscompares = 0;
  int          to_pulses = 0;

  always #5 clk = ~clk;

  eth_tx_arbiter #(.TIMEOUT(TO), .STARVE_MAX(SM)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_arp_data (s_data[0]), .i_arp_vld (s_vld[0]), .i_arp_sop (s_sop[0]),
    .i_arp_eop  (s_eop[0]),  .o_arp_rdy (s_rdy[0]),
    .i_ping_data(s_data[1]), .i_ping_vld(s_vld[1]), .i_ping_sop(s_sop[1]),
    .i_ping_eop (s_eop[1]),  .o_ping_rdy(s_rdy[1]),
    .i_udp_data (s_data[2]), .i_udp_vld (s_vld[2]), .i_udp_sop (s_sop[2]),
    .i_udp_eop  (s_eop[2]),  .o_udp_rdy (s_rdy[2]),
    .o_tx_data  (tx_data),
    .o_tx_vld   (tx_vld),
    .o_tx_sop   (tx_sop),
    .o_tx_eop   (tx_eop),
    .i_tx_rdy   (tx_rdy),
    .o_grant    (grant),
    .o_busy     (busy),
    .o_timeout  (timeout),
    .o_drop_cnt (drop_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic add_pkt(input int s, input int n, input logic [31:0] base, input bit to_exp);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.data  = base + 32'(i);
      b.sop   = (i == 0);
      b.eop   = (i == n - 1);
      b.owner = 2'(s + 1);
      src_q[s].push_back(b);
      if (to_exp) exp_q.push_back(b);
    end
  endtask

  // One clock: present queue heads, sample at negedge, return just after posedge
  task automatic step();
    beat_t b;
    for (int s = 0; s < 3; s++) begin
      if (!stall[s] && src_q[s].size() != 0) begin
        b = src_q[s][0];
        s_vld[s]  = 1'b1;
        s_data[s] = b.data;
        s_sop[s]  = b.sop;
        s_eop[s]  = b.eop;
      end else begin
        s_vld[s]  = 1'b0;
        s_data[s] = '0;
        s_sop[s]  = 1'b0;
        s_eop[s]  = 1'b0;
      end
    end
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      if (s_vld[s] && s_rdy[s]) void'(src_q[s].pop_front());
    end
    grant_trace.push_back(grant);
    if (timeout) to_pulses++;
    if (tx_vld && tx_rdy) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", 32'(tx_vld), 32'd0);
      end else begin
        b = exp_q.pop_front();
        chk("tx_data",  tx_data,     b.data);
        chk("tx_sop",   32'(tx_sop), 32'(b.sop));
        chk("tx_eop",   32'(tx_eop), 32'(b.eop));
        chk("tx_owner", 32'(grant),  32'(b.owner));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_until_empty(input string tag, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    chk({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    beat_t b;
    int    n;
    rst_n  = 1'b0;
    tx_rdy = 1'b1;
    for (int s = 0; s < 3; s++) begin
      stall[s] = 1'b0;
      s_vld[s] = 1'b0;
      s_sop[s] = 1'b0;
      s_eop[s] = 1'b0;
      s_data[s] = '0;
    end
    exp_tr = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd0, 2'd2, 2'd2, 2'd2, 2'd0, 2'd3, 2'd3, 2'd3, 2'd0};

    // Reset: a stray PING beat must not be accepted while rst_n is low
    b = '{data: 32'hDEAD_BEEF, sop: 1'b0, eop: 1'b0, owner: 2'd2};
    src_q[1].push_back(b);
    step();
    step();
    chk("rst_ping_rdy", 32'(s_rdy[1]), 32'd0);
    chk("rst_tx_vld",   32'(tx_vld),   32'd0);
    chk("rst_grant",    32'(grant),    32'd0);
    chk("rst_busy",     32'(busy),     32'd0);
    chk("rst_timeout",  32'(timeout),  32'd0);
    chk("rst_drop",     32'(drop_cnt), 32'd0);
    src_q[1].delete();
    rst_n = 1'b1;
    step();

    // All three request together: ARP, PING, UDP with one IDLE cycle between
    add_pkt(0, 3, 32'hA000_0000, 1'b1);
    add_pkt(1, 3, 32'hB000_0000, 1'b1);
    add_pkt(2, 3, 32'hC000_0000, 1'b1);
    grant_trace.delete();
    repeat (13) step();
    for (int i = 0; i < 13; i++) chk($sformatf("grant_seq%0d", i), 32'(grant_trace[i]), 32'(exp_tr[i]));
    chk("prio_drained", 32'(exp_q.size()), 32'd0);
    chk("prio_starve",  32'(dut.starve_cnt_q), 32'd0);

    // UDP starvation: four ARP packets, then UDP is forced ahead of the fifth
    for (int i = 0; i < 4; i++) add_pkt(0, 2, 32'h1000_0000 + 32'(i * 16), 1'b1);
    add_pkt(2, 2, 32'h2000_0000, 1'b1);
    add_pkt(0, 2, 32'h1000_0040, 1'b1);
    n = 0;
    while (exp_q.size() > 4 && n < 60) begin
      step();
      n++;
    end
    chk("starve_at_max", 32'(dut.starve_cnt_q), 32'(SM));
    run_until_empty("starve", 60);
    step();
    chk("starve_cleared", 32'(dut.starve_cnt_q), 32'd0);

    // UDP stalls after two beats: timeout, forced zero eop beat, drain to eop
    add_pkt(2, 6, 32'hD000_0000, 1'b0);
    exp_q.push_back(src_q[2][0]);
    exp_q.push_back(src_q[2][1]);
    b = '{data: 32'h0, sop: 1'b0, eop: 1'b1, owner: 2'd3};
    exp_q.push_back(b);
    n = 0;
    while (src_q[2].size() > 4 && n < 20) begin
      step();
      n++;
    end
    chk("udp_two_beats", 32'(src_q[2].size()), 32'd4);
    stall[2]  = 1'b1;
    to_pulses = 0;
    n = 0;
    while (to_pulses == 0 && n < 40) begin
      step();
      n++;
    end
    chk("timeout_latency", 32'(n), 32'(TO + 1));
    stall[2] = 1'b0;
    repeat (6) step();
    chk("timeout_pulses", 32'(to_pulses),        32'd1);
    chk("drain_consumed", 32'(src_q[2].size()),  32'd0);
    chk("drain_exp",      32'(exp_q.size()),     32'd0);
    chk("drain_idle",     32'(busy),             32'd0);
    chk("drain_grant",    32'(grant),            32'd0);
    chk("drain_no_drop",  32'(drop_cnt),         32'd0);

    // Downstream back-pressure for 100 cycles must not time out
    add_pkt(0, 4, 32'hE000_0000, 1'b1);
    n = 0;
    while (src_q[0].size() > 2 && n < 20) begin
      step();
      n++;
    end
    tx_rdy    = 1'b0;
    to_pulses = 0;
    repeat (100) step();
    chk("bp_no_timeout", 32'(to_pulses),    32'd0);
    chk("bp_grant",      32'(grant),        32'd1);
    chk("bp_tx_vld",     32'(tx_vld),       32'd1);
    chk("bp_pending",    32'(exp_q.size()), 32'd2);
    tx_rdy = 1'b1;
    run_until_empty("bp", 20);
    step();

    // 300 stray PING beats while IDLE: all dropped, counter saturates
    for (int i = 0; i < 300; i++) begin
      b = '{data: 32'(i), sop: 1'b0, eop: 1'b0, owner: 2'd2};
      src_q[1].push_back(b);
    end
    n = 0;
    while (src_q[1].size() != 0 && n < 400) begin
      step();
      n++;
    end
    chk("stray_cycles", 32'(n),        32'd300);
    chk("stray_sat",    32'(drop_cnt), 32'd255);
    chk("stray_busy",   32'(busy),     32'd0);

    // Reset mid UDP packet: abandoned, counters cleared, arbitration restarts
    add_pkt(2, 5, 32'hF000_0000, 1'b1);
    n = 0;
    while (src_q[2].size() > 3 && n < 20) begin
      step();
      n++;
    end
    rst_n = 1'b0;
    step();
    chk("midrst_tx_vld",  32'(tx_vld),   32'd0);
    chk("midrst_udp_rdy", 32'(s_rdy[2]), 32'd0);
    rst_n = 1'b1;
    chk("midrst_grant",   32'(grant),    32'd0);
    chk("midrst_busy",    32'(busy),     32'd0);
    chk("midrst_timeout", 32'(timeout),  32'd0);
    chk("midrst_drop",    32'(drop_cnt), 32'd0);
    chk("midrst_starve",  32'(dut.starve_cnt_q), 32'd0);
    chk("midrst_idle",    32'(dut.idle_cnt_q),   32'd0);
    src_q[2].delete();
    exp_q.delete();
    step();
    chk("postrst_tx_vld", 32'(tx_vld), 32'd0);
    add_pkt(1, 2, 32'h1111_0000, 1'b1);
    run_until_empty("postrst", 20);
    chk("postrst_drop",   32'(drop_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
